// File: rtl/cpu_isa_pkg.sv
// Instruction-set constants shared by the decoder and its reset stretcher.
package cpu_isa_pkg;

  localparam int RST_STAGES_DEF = 2;

  // Opcode prefixes, compared against the top bits of the instruction word
  localparam logic       OPC_LOAD = 1'b0;     // ir[7]
  localparam logic [1:0] OPC_MOVE = 2'b10;    // ir[7:6]
  localparam logic [2:0] OPC_ALU  = 3'b110;   // ir[7:5]
  localparam logic [3:0] OPC_JMP  = 4'hE;     // ir[7:4]
  localparam logic [3:0] OPC_JNZ  = 4'hF;     // ir[7:4]

  // Register codes used as load/move destination and move source.
  // Code 4 is o_reg as a destination and the ALU result r as a source.
  localparam logic [2:0] CODE_X0 = 3'd0;
  localparam logic [2:0] CODE_X1 = 3'd1;
  localparam logic [2:0] CODE_Y0 = 3'd2;
  localparam logic [2:0] CODE_Y1 = 3'd3;
  localparam logic [2:0] CODE_OR = 3'd4;
  localparam logic [2:0] CODE_M  = 3'd5;
  localparam logic [2:0] CODE_I  = 3'd6;
  localparam logic [2:0] CODE_DM = 3'd7;

  // ALU-space words with ir[3]=1 that carry sequencer meaning
  localparam logic [7:0] NOP_C8 = 8'hC8;
  localparam logic [7:0] NOP_CF = 8'hCF;
  localparam logic [7:0] NOP_D8 = 8'hD8;
  localparam logic [7:0] NOP_DF = 8'hDF;

  typedef enum logic [2:0] {
    CLS_LOAD,
    CLS_MOVE,
    CLS_ALU,
    CLS_JMP,
    CLS_JNZ
  } instr_class_e;

  // Exactly one class matches any 8-bit word
  function automatic instr_class_e classify(input logic [7:0] word);
    if (word[7] == OPC_LOAD)            return CLS_LOAD;
    else if (word[7:6] == OPC_MOVE)     return CLS_MOVE;
    else if (word[7:5] == OPC_ALU)      return CLS_ALU;
    else if (word[7:4] == OPC_JMP)      return CLS_JMP;
    else                                return CLS_JNZ;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Asynchronous-assert, synchronous-deassert reset stretcher.
// sync_reset rises with reset_n low and falls RST_STAGES edges after release.
module reset_sync #(
  parameter int RST_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  output logic sync_reset
);

  logic [RST_STAGES-1:0] sr_q;
  logic [RST_STAGES-1:0] sr_d;

  // Shift zeros in once the board reset is released
  always_comb begin
    sr_d = {sr_q[RST_STAGES-2:0], 1'b0};
  end

  // Stage register, preset to all ones by the board reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sr_q <= '1;
    else          sr_q <= sr_d;
  end

  assign sync_reset = sr_q[RST_STAGES-1];

endmodule

// File: rtl/instruction_decoder.sv
// Instruction register and decoder: registers the program-memory word and
// drives sequencer jump/loop strobes and computational-unit controls.
module instruction_decoder
  import cpu_isa_pkg::*;
#(
  parameter int RST_STAGES = RST_STAGES_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] pm_data,
  output logic       sync_reset,
  output logic [7:0] ir,
  output logic       jmp,
  output logic       jmp_nz,
  output logic [3:0] jmp_addr,
  output logic       NOPC8,
  output logic       NOPCF,
  output logic       NOPD8,
  output logic       NOPDF,
  output logic [7:0] ld_en,
  output logic       r_en,
  output logic [2:0] src_sel,
  output logic       imm_sel,
  output logic [2:0] alu_func,
  output logic       alu_src,
  output logic       i_incr,
  output logic       loop_cfg_err
);

  logic [7:0]   ir_q, ir_d;
  logic         valid_q, valid_d;
  logic         loop_armed_q, loop_armed_d;
  logic         loop_cfg_err_q, loop_cfg_err_d;
  logic [2:0]   dst;
  logic [2:0]   src;
  instr_class_e cls;

  reset_sync #(.RST_STAGES(RST_STAGES)) u_reset_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .sync_reset (sync_reset)
  );

  assign dst = ir_q[5:3];
  assign src = ir_q[2:0];
  assign cls = classify(ir_q);

  // Next state: capture the fetched word, qualify it, track loop setup order
  always_comb begin
    ir_d           = pm_data;
    valid_d        = ~sync_reset;
    loop_armed_d   = loop_armed_q;
    loop_cfg_err_d = loop_cfg_err_q;
    if (sync_reset) begin
      loop_armed_d   = 1'b0;
      loop_cfg_err_d = 1'b0;
    end else if (NOPC8) begin
      loop_armed_d = 1'b1;
    end else if (NOPCF) begin
      // Loop end without a preceding loop start is misuse; the strobe still goes out
      if (loop_armed_q) loop_armed_d   = 1'b0;
      else              loop_cfg_err_d = 1'b1;
    end
  end

  // State registers, cleared immediately by the board reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_q           <= 8'h00;
      valid_q        <= 1'b0;
      loop_armed_q   <= 1'b0;
      loop_cfg_err_q <= 1'b0;
    end else begin
      ir_q           <= ir_d;
      valid_q        <= valid_d;
      loop_armed_q   <= loop_armed_d;
      loop_cfg_err_q <= loop_cfg_err_d;
    end
  end

  // Decode: field selects always follow ir, strobes/enables need a valid word
  always_comb begin
    ld_en    = '0;
    r_en     = 1'b0;
    imm_sel  = 1'b0;
    alu_src  = 1'b0;
    jmp      = 1'b0;
    jmp_nz   = 1'b0;
    NOPC8    = 1'b0;
    NOPCF    = 1'b0;
    NOPD8    = 1'b0;
    NOPDF    = 1'b0;
    i_incr   = 1'b0;
    jmp_addr = ir_q[3:0];
    src_sel  = ir_q[2:0];
    alu_func = ir_q[2:0];
    if (valid_q) begin
      unique case (cls)
        CLS_LOAD: begin
          ld_en   = 8'b1 << ir_q[6:4];
          imm_sel = 1'b1;
          i_incr  = (ir_q[6:4] == CODE_DM);
        end
        CLS_MOVE: begin
          // A move onto itself is the NOP encoding: no write, no i post-increment
          if (dst != src) begin
            ld_en  = 8'b1 << dst;
            i_incr = (dst == CODE_DM) || (src == CODE_DM);
          end
        end
        CLS_ALU: begin
          if (!ir_q[3]) begin
            r_en    = 1'b1;
            alu_src = ir_q[4];
          end else begin
            NOPC8 = (ir_q == NOP_C8);
            NOPCF = (ir_q == NOP_CF);
            NOPD8 = (ir_q == NOP_D8);
            NOPDF = (ir_q == NOP_DF);
          end
        end
        CLS_JMP: jmp    = 1'b1;
        CLS_JNZ: jmp_nz = 1'b1;
        default: ;
      endcase
    end
  end

  assign ir           = ir_q;
  assign loop_cfg_err = loop_cfg_err_q;

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed scoreboard bench for instruction_decoder.
module tb_instruction_decoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] pm_data;
  logic       sync_reset;
  logic [7:0] ir;
  logic       jmp, jmp_nz;
  logic [3:0] jmp_addr;
  logic       NOPC8, NOPCF, NOPD8, NOPDF;
  logic [7:0] ld_en;
  logic       r_en;
  logic [2:0] src_sel;
  logic       imm_sel;
  logic [2:0] alu_func;
  logic       alu_src;
  logic       i_incr;
  logic       loop_cfg_err;

  instruction_decoder #(.RST_STAGES(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pm_data      (pm_data),
    .sync_reset   (sync_reset),
    .ir           (ir),
    .jmp          (jmp),
    .jmp_nz       (jmp_nz),
    .jmp_addr     (jmp_addr),
    .NOPC8        (NOPC8),
    .NOPCF        (NOPCF),
    .NOPD8        (NOPD8),
    .NOPDF        (NOPDF),
    .ld_en        (ld_en),
    .r_en         (r_en),
    .src_sel      (src_sel),
    .imm_sel      (imm_sel),
    .alu_func     (alu_func),
    .alu_src      (alu_src),
    .i_incr       (i_incr),
    .loop_cfg_err (loop_cfg_err)
  );

  always #5 clk = ~clk;

  // Observed decode vector:
  // {ir, ld_en, r_en, imm_sel, jmp, jmp_nz, jmp_addr, C8, CF, D8, DF, i_incr, src_sel, alu_func, err}
  logic [35:0] obs;
  assign obs = {ir, ld_en, r_en, imm_sel, jmp, jmp_nz, jmp_addr,
                NOPC8, NOPCF, NOPD8, NOPDF, i_incr, src_sel, alu_func, loop_cfg_err};

  typedef struct {
    logic [35:0] vec;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // ctl = {r_en, imm_sel, jmp, jmp_nz}; strb = {C8, CF, D8, DF}
  function automatic logic [35:0] expv(input logic [7:0] w, input logic [7:0] ld,
                                       input logic [3:0] ctl, input logic [3:0] strb,
                                       input logic iinc, input logic err);
    return {w, ld, ctl, w[3:0], strb, iinc, w[2:0], w[2:0], err};
  endfunction

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, got, want);
      $error("check %s", tag);
    end
  endtask

  // Drive one word, queue its expected decode, compare once it reaches ir
  task automatic step(input logic [7:0] w, input string tag, input logic [7:0] ld,
                      input logic [3:0] ctl, input logic [3:0] strb,
                      input logic iinc, input logic err);
    exp_t e;
    @(negedge clk);
    pm_data = w;
    e.vec = expv(w, ld, ctl, strb, iinc, err);
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 36'd1, 36'd0);
    end else begin
      e = sb.pop_front();
      check(e.tag, obs, e.vec);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    pm_data = 8'hE5;
    #12;
    check("rst_ir",   {28'd0, ir},         36'h00);
    check("rst_sync", {35'd0, sync_reset}, 36'd1);
    check("rst_jmp",  {35'd0, jmp},        36'd0);
    check("rst_err",  {35'd0, loop_cfg_err}, 36'd0);

    // Release: sync_reset high after edge 1, low after edge 2, valid word after edge 3
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("rel_sync_%0d", k), {35'd0, sync_reset}, {35'd0, (k == 0)});
      check($sformatf("rel_jmp_%0d", k),  {35'd0, jmp},        {35'd0, (k == 2)});
    end
    check("rel_jaddr", {32'd0, jmp_addr}, 36'd5);

    // Loads and moves
    step(8'h37, "load_y1",     8'h08, 4'b0100, 4'b0000, 1'b0, 1'b0);
    step(8'h8F, "mv_x1_dm",    8'h02, 4'b0000, 4'b0000, 1'b1, 1'b0);
    step(8'hBE, "mv_dm_i",     8'h80, 4'b0000, 4'b0000, 1'b1, 1'b0);
    step(8'h92, "mv_nop_y0",   8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0);
    step(8'hBF, "mv_nop_dm",   8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0);
    step(8'h70, "load_dm",     8'h80, 4'b0100, 4'b0000, 1'b1, 1'b0);
    // ALU
    step(8'hD3, "alu_d3",      8'h00, 4'b1000, 4'b0000, 1'b0, 1'b0);
    check("alu_src_d3", {35'd0, alu_src}, 36'd1);
    step(8'hCB, "alu_cb_none", 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0);
    // Loop ordering: C8 then CF is legal, a second CF is flagged on the following edge
    step(8'hC8, "nop_c8",      8'h00, 4'b0000, 4'b1000, 1'b0, 1'b0);
    step(8'hCF, "nop_cf_ok",   8'h00, 4'b0000, 4'b0100, 1'b0, 1'b0);
    step(8'hCF, "nop_cf_bad",  8'h00, 4'b0000, 4'b0100, 1'b0, 1'b0);
    step(8'hD8, "nop_d8",      8'h00, 4'b0000, 4'b0010, 1'b0, 1'b1);
    step(8'hDF, "nop_df",      8'h00, 4'b0000, 4'b0001, 1'b0, 1'b1);
    // Jumps
    step(8'hF2, "jnz_2",       8'h00, 4'b0001, 4'b0000, 1'b0, 1'b1);
    step(8'hE0, "jmp_0",       8'h00, 4'b0010, 4'b0000, 1'b0, 1'b1);
    // Error stays set through a legal C8/CF pair
    step(8'hC8, "c8_sticky",   8'h00, 4'b0000, 4'b1000, 1'b0, 1'b1);
    step(8'hCF, "cf_sticky",   8'h00, 4'b0000, 4'b0100, 1'b0, 1'b1);
    step(8'hE3, "jmp_3",       8'h00, 4'b0010, 4'b0000, 1'b0, 1'b1);

    // Asynchronous reset between edges
    #2;
    reset_n = 1'b0;
    #1;
    check("async_jmp",  {35'd0, jmp},          36'd0);
    check("async_ir",   {28'd0, ir},           36'h00);
    check("async_sync", {35'd0, sync_reset},   36'd1);
    check("async_err",  {35'd0, loop_cfg_err}, 36'd0);

    // Second release: nothing decodes until valid returns
    @(negedge clk);
    reset_n = 1'b1;
    pm_data = 8'h37;
    repeat (2) @(posedge clk);
    #1;
    check("rel2_sync", {35'd0, sync_reset}, 36'd0);
    check("rel2_ld",   {28'd0, ld_en},      36'h00);
    step(8'h37, "rel2_load",  8'h08, 4'b0100, 4'b0000, 1'b0, 1'b0);
    // CF with nothing armed after reset
    step(8'hCF, "cf_unarmed", 8'h00, 4'b0000, 4'b0100, 1'b0, 1'b0);
    step(8'h00, "load_x0",    8'h01, 4'b0100, 4'b0000, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
